conv_tile_loader: RTL and testbench
===================================

CONV_TILE_LOADER -- requirements
Module: conv_tile_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter DIM, default 8, meaning tile edge length (legal range 2..16).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  meaning an upstream pixel is present.
REQ-006 SHALL have port s_data  input  DATA_W  meaning the upstream pixel, in raster order (row-major).
REQ-007 SHALL have port s_ready  output  1  meaning the loader accepts a pixel this cycle.
REQ-008 SHALL have port start  output  1  meaning a one-cycle pulse that launches the convolution controller.
REQ-009 SHALL have port conv_done  input  1  meaning the completion flag from the convolution controller, treated as a level that may stay high.
REQ-010 SHALL have port rd_i  input  4  meaning the buffer read row index.
REQ-011 SHALL have port rd_j  input  4  meaning the buffer read column index.
REQ-012 SHALL have port rd_data  output  DATA_W  meaning the registered buffer read data.
REQ-013 SHALL have port busy  output  1  meaning the tile is handed off and the loader is awaiting completion.
REQ-014 SHALL have port tiles_done  output  8  meaning the count of completed tiles.

Function
REQ-015 SHALL implement FSM states FILL, LAUNCH and WAIT_DONE.
REQ-016 SHALL drive s_ready=1 only in FILL; a pixel is accepted when s_valid and s_ready are both 1.
REQ-017 SHALL write each accepted pixel to buffer[row][col], with row and col starting at 0.
REQ-018 SHALL advance col by 1 per accepted pixel; at col=DIM-1, col SHALL wrap to 0 and row SHALL increment.
REQ-019 SHALL, on acceptance at row=DIM-1, col=DIM-1, go FILL->LAUNCH next cycle and clear row and col to 0.
REQ-020 SHALL hold row and col when s_valid=0 in FILL; bubbles are allowed anywhere in a tile.
REQ-021 SHALL assert start=1 for exactly the one cycle spent in LAUNCH, then go to WAIT_DONE.
REQ-022 SHALL assert busy=1 in LAUNCH and WAIT_DONE, and 0 in FILL.
REQ-023 SHALL register conv_done into conv_done_q every cycle; the completion event is conv_done=1 and conv_done_q=0 (rising edge).
REQ-024 SHALL ignore a completion event in FILL or LAUNCH; only an event in WAIT_DONE counts.
REQ-025 SHALL, on a completion event in WAIT_DONE, go to FILL next cycle and increment tiles_done, which wraps 255->0.
REQ-026 SHALL not start a second tile while conv_done stays high: a persistent high level produces no new event.
REQ-027 SHALL give rd_data one-cycle latency: rd_data(t+1)=buffer[rd_i(t)][rd_j(t)], in every state.
REQ-028 SHALL return rd_data=0 when rd_i>=DIM or rd_j>=DIM.
REQ-029 SHALL, when a read and a write hit the same address in one cycle, return the old buffer contents.
REQ-030 SHALL retain buffer contents until overwritten, including across tiles and reset.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, set state=FILL, row=0, col=0, start=0, rd_data=0, tiles_done=0 and conv_done_q=0.
REQ-032 SHALL derive s_ready=1 and busy=0 from the reset state in the first cycle after reset.
REQ-033 SHALL abandon a tile when reset occurs mid-FILL or mid-WAIT_DONE; the next accepted pixel is written to [0][0], with no start pulse.
REQ-034 SHALL not reset the buffer storage.

Verification
REQ-035 SHALL cover continuous fill: 64 pixels with values 0..63, s_valid held 1 -> start pulses once, 1 cycle after the 64th accept; busy=1; s_ready=0.
REQ-036 SHALL cover readback: after the fill, read rd_i=3, rd_j=5 -> rd_data=29 one cycle later; read rd_i=8, rd_j=0 -> rd_data=0.
REQ-037 SHALL cover completion: conv_done 0->1 in WAIT_DONE -> FILL next cycle, tiles_done=1; conv_done held high through a second 64-pixel fill -> start still pulses but no completion until conv_done drops to 0 then rises.
REQ-038 SHALL cover bubbles: s_valid toggled randomly over 64 accepts -> buffer[r][c] holds the (8r+c)-th accepted value; exactly one start.
REQ-039 SHALL cover ignored and wrapped events: a conv_done rise during FILL -> ignored, tiles_done unchanged; 256 full tile cycles -> tiles_done=0.
REQ-040 SHALL cover reset mid-fill: rst after 20 pixels, then 64 new pixels -> start occurs only after all 64, and buffer[0][0] = the first post-reset pixel.

Source files
------------

// File: rtl/conv_tile_loader.sv
// rtl/conv_tile_loader.sv - raster pixel stream to DIMxDIM tile buffer with convolution handshake
module conv_tile_loader #(
    parameter int DATA_W = 8,
    parameter int DIM    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              start,
    input  logic              conv_done,
    input  logic [3:0]        rd_i,
    input  logic [3:0]        rd_j,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [7:0]        tiles_done
);

    localparam int RW = (DIM > 2) ? $clog2(DIM) : 1;
    localparam int AW = $clog2(DIM * DIM);

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT_DONE} state_t;

    state_t            state;
    logic [RW-1:0]     row;
    logic [RW-1:0]     col;
    logic              conv_done_q;
    logic [DATA_W-1:0] mem [DIM*DIM];

    logic              accept;
    logic              last_col;
    logic              last_pix;
    logic              done_evt;
    logic              rd_in_range;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    assign s_ready     = (state == FILL);
    assign busy        = (state != FILL);
    assign accept      = s_valid & s_ready;
    assign last_col    = (col == RW'(DIM - 1));
    assign last_pix    = last_col && (row == RW'(DIM - 1));
    // Completion is the rising edge only, so a level held high cannot retrigger
    assign done_evt    = conv_done & ~conv_done_q;
    assign wr_addr     = AW'(row) * AW'(DIM) + AW'(col);
    assign rd_addr     = AW'(rd_i) * AW'(DIM) + AW'(rd_j);
    assign rd_in_range = ({1'b0, rd_i} < 5'(DIM)) && ({1'b0, rd_j} < 5'(DIM));

    // Tile sequencing: raster position, launch pulse and completed-tile count
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            row        <= '0;
            col        <= '0;
            start      <= 1'b0;
            tiles_done <= 8'd0;
        end else begin
            start <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (last_pix) begin
                            row   <= '0;
                            col   <= '0;
                            state <= LAUNCH;
                            start <= 1'b1;
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + RW'(1);
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_evt) begin
                        state      <= FILL;
                        tiles_done <= tiles_done + 8'd1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Delayed copy of conv_done for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_done_q <= 1'b0;
        end else begin
            conv_done_q <= conv_done;
        end
    end

    // Buffer storage survives reset so a tile can still be read back afterwards
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= s_data;
        end
    end

    // Registered read port; a same-cycle write is not forwarded, so old data is returned
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_in_range) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_conv_tile_loader.sv
// tb/tb_conv_tile_loader.sv - self-checking bench for conv_tile_loader
module tb_conv_tile_loader;

    localparam int DIM  = 8;
    localparam int NPIX = DIM * DIM;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       start;
    logic       conv_done;
    logic [3:0] rd_i;
    logic [3:0] rd_j;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] tiles_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: the tile as an array indexed by acceptance order, plus a tile count
    logic [7:0] mdl [NPIX];
    int         mdl_tiles = 0;

    conv_tile_loader #(.DATA_W(8), .DIM(DIM)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .start      (start),
        .conv_done  (conv_done),
        .rd_i       (rd_i),
        .rd_j       (rd_j),
        .rd_data    (rd_data),
        .busy       (busy),
        .tiles_done (tiles_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_read(input int i, input int j);
        if (i >= DIM || j >= DIM) return 8'd0;
        return mdl[i * DIM + j];
    endfunction

    // Streams one whole tile; checks start stays low during fill and pulses once after the last accept
    task automatic fill_tile(input bit bubbles, input bit seq);
        int acc   = 0;
        int guard = 0;
        while (acc < NPIX && guard < 4000) begin
            @(negedge clk);
            checks++;
            if (start !== 1'b0) begin
                failures++;
                $display("FAIL fill_early_start acc=%0d start=%b required 0", acc, start);
            end
            s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = seq ? 8'(acc) : 8'($urandom);
            if (s_valid && s_ready) begin
                mdl[acc] = s_data;
                acc++;
            end
            guard++;
        end
        if (acc < NPIX) begin
            checks++;
            failures++;
            $display("FAIL fill_timeout accepted=%0d required %0d", acc, NPIX);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL launch start=%b busy=%b s_ready=%b required 1 1 0", start, busy, s_ready);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL wait_done start=%b busy=%b s_ready=%b required 0 1 0", start, busy, s_ready);
        end
    endtask

    task automatic test_readback(input int n);
        logic [7:0] expv;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (rd_data !== expv) begin
                    failures++;
                    $display("FAIL readback i=%0d j=%0d rd_data=%0d required %0d", rd_i, rd_j, rd_data, expv);
                end
            end
            rd_i = 4'($urandom_range(0, 9));
            rd_j = 4'($urandom_range(0, 9));
            expv = exp_read(int'(rd_i), int'(rd_j));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; conv_done = 1'b0; rd_i = 4'd15; rd_j = 4'd15;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tiles_done !== 8'd0 || rd_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_state s_ready=%b busy=%b start=%b tiles=%0d rd=%0d required 1 0 0 0 0",
                     s_ready, busy, start, tiles_done, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset s_ready=%b busy=%b required 1 0", s_ready, busy);
        end
        mdl_tiles = 0;
    endtask

    task automatic test_continuous_fill;
        fill_tile(1'b0, 1'b1);
        @(negedge clk);
        rd_i = 4'd3; rd_j = 4'd5;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'd29) begin
            failures++;
            $display("FAIL read_3_5 rd_data=%0d required 29", rd_data);
        end
        rd_i = 4'd8; rd_j = 4'd0;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'd0) begin
            failures++;
            $display("FAIL read_8_0 rd_data=%0d required 0", rd_data);
        end
        test_readback(40);
    endtask

    task automatic test_completion;
        conv_done = 1'b1;
        @(negedge clk);
        mdl_tiles++;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || tiles_done !== 8'(mdl_tiles)) begin
            failures++;
            $display("FAIL complete1 s_ready=%b busy=%b tiles=%0d required 1 0 %0d", s_ready, busy, tiles_done, mdl_tiles);
        end
        fill_tile(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tiles_done !== 8'(mdl_tiles)) begin
            failures++;
            $display("FAIL held_level busy=%b tiles=%0d required 1 %0d", busy, tiles_done, mdl_tiles);
        end
        conv_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL fall_no_event busy=%b required 1", busy);
        end
        conv_done = 1'b1;
        @(negedge clk);
        mdl_tiles++;
        conv_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || tiles_done !== 8'(mdl_tiles)) begin
            failures++;
            $display("FAIL complete2 busy=%b tiles=%0d required 0 %0d", busy, tiles_done, mdl_tiles);
        end
    endtask

    task automatic test_bubbles;
        fill_tile(1'b1, 1'b0);
        test_readback(60);
        conv_done = 1'b1;
        @(negedge clk);
        mdl_tiles++;
        conv_done = 1'b0;
        checks++;
        if (tiles_done !== 8'(mdl_tiles) || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL bubble_complete tiles=%0d s_ready=%b required %0d 1", tiles_done, s_ready, mdl_tiles);
        end
    endtask

    task automatic test_ignored_event;
        conv_done = 1'b1;
        repeat (2) @(negedge clk);
        conv_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tiles_done !== 8'(mdl_tiles) || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_event tiles=%0d s_ready=%b busy=%b required %0d 1 0", tiles_done, s_ready, busy, mdl_tiles);
        end
    endtask

    task automatic test_wrap;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_tiles = 0;
        rd_i = 4'd2; rd_j = 4'd6;
        @(negedge clk);
        checks++;
        if (rd_data !== exp_read(2, 6)) begin
            failures++;
            $display("FAIL retain_across_reset rd_data=%0d required %0d", rd_data, exp_read(2, 6));
        end
        for (int t = 0; t < 256; t++) begin
            fill_tile(1'b0, 1'b0);
            conv_done = 1'b1;
            @(negedge clk);
            conv_done = 1'b0;
            mdl_tiles++;
        end
        checks++;
        if (tiles_done !== 8'(mdl_tiles % 256) || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL tiles_wrap tiles=%0d s_ready=%b required %0d 1", tiles_done, s_ready, mdl_tiles % 256);
        end
    endtask

    task automatic test_reset_mid_fill;
        logic [7:0] first_pix;
        int acc = 0;
        while (acc < 20) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            if (s_ready) begin
                mdl[acc] = s_data;
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_tiles = 0;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tiles_done !== 8'd0) begin
            failures++;
            $display("FAIL mid_fill_reset s_ready=%b busy=%b start=%b tiles=%0d required 1 0 0 0",
                     s_ready, busy, start, tiles_done);
        end
        fill_tile(1'b1, 1'b0);
        first_pix = mdl[0];
        rd_i = 4'd0; rd_j = 4'd0;
        @(negedge clk);
        checks++;
        if (rd_data !== first_pix) begin
            failures++;
            $display("FAIL first_pixel rd_data=%0d required %0d", rd_data, first_pix);
        end
        test_readback(30);
    endtask

    initial begin
        test_reset();
        test_continuous_fill();
        test_completion();
        test_bubbles();
        test_ignored_event();
        test_wrap();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
